// File: rtl/tjmono2_rx_stream_adapter.sv
// Rx FIFO to valid/ready stream adapter: tag filter, 2-entry skid buffer, IDLE/RUN/DRAIN control.
// Define TJMONO2_STREAM_TRAILER_EN to append a word-count trailer at the end of each drain.
module tjmono2_rx_stream_adapter #(
    parameter logic [3:0] DATA_IDENTIFIER = 4'h0
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST_N,
    input  logic        ENABLE,
    input  logic        CLR_CNT,
    input  logic        FIFO_EMPTY,
    input  logic [31:0] FIFO_DATA,
    output logic        FIFO_READ,
    output logic [31:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] WORD_CNT,
    output logic [15:0] DROP_CNT,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    logic [1:0]  r_cnt;
    logic [31:0] r_buf0;
    logic [31:0] r_buf1;
    logic [31:0] r_word_cnt;
    logic [31:0] w_word_cnt_nxt;
    logic [15:0] r_drop_cnt;
    logic        w_head_match;
    logic        w_trl_valid;
    logic        w_xfer;
    logic        w_data_xfer;
    logic        w_push;
    logic        w_drop;
    logic [31:0] w_trl_word;

    // Assertion is asynchronous; release is re-timed so no flop leaves reset on a partial edge.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_rst_sync <= 2'b00;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

`ifdef TJMONO2_STREAM_TRAILER_EN
    logic [23:0] r_trl_cnt;

    // Tracks WORD_CNT outside DRAIN, then counts only drain transfers so the trailer stays stable.
    always_ff @(posedge BUS_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_trl_cnt <= 24'd0;
        end else if (r_state != DRAIN) begin
            r_trl_cnt <= w_word_cnt_nxt[23:0];
        end else if (w_data_xfer) begin
            r_trl_cnt <= r_trl_cnt + 24'd1;
        end
    end

    assign w_trl_valid = (r_state == DRAIN) && (r_cnt == 2'd0);
    assign w_trl_word  = {DATA_IDENTIFIER, 4'hE, r_trl_cnt};
`else
    assign w_trl_valid = 1'b0;
    assign w_trl_word  = 32'd0;
`endif

    assign w_head_match = (FIFO_DATA[31:28] == DATA_IDENTIFIER);
    assign OUT_VALID    = (r_cnt != 2'd0) || w_trl_valid;
    assign OUT_DATA     = w_trl_valid ? w_trl_word : r_buf0;
    assign w_xfer       = OUT_VALID && OUT_READY;
    assign w_data_xfer  = w_xfer && (r_cnt != 2'd0);

    assign FIFO_READ = (r_state == RUN) && !FIFO_EMPTY &&
                       (!w_head_match || (r_cnt < 2'd2) || w_xfer);
    assign w_push    = FIFO_READ && w_head_match;
    assign w_drop    = FIFO_READ && !w_head_match;

    assign BUSY     = (r_state != IDLE);
    assign WORD_CNT = r_word_cnt;
    assign DROP_CNT = r_drop_cnt;

    always_ff @(posedge BUS_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves the next state unassigned (no latch).
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (ENABLE) w_state_nxt = RUN;
            RUN:     if (!ENABLE) w_state_nxt = DRAIN;
`ifdef TJMONO2_STREAM_TRAILER_EN
            DRAIN:   if (w_trl_valid && OUT_READY) w_state_nxt = IDLE;
`else
            DRAIN:   if (r_cnt == 2'd0) w_state_nxt = IDLE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Two-entry in-order buffer; head is always r_buf0.
    always_ff @(posedge BUS_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            // NOTE: buffer words are reset too, because the head drives OUT_DATA directly.
            r_cnt  <= 2'd0;
            r_buf0 <= 32'd0;
            r_buf1 <= 32'd0;
        end else begin
            unique case ({w_push, w_data_xfer})
                2'b10: begin
                    if (r_cnt == 2'd0) r_buf0 <= FIFO_DATA;
                    else               r_buf1 <= FIFO_DATA;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_buf0 <= FIFO_DATA;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= FIFO_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_word_cnt_nxt = CLR_CNT     ? 32'd0 :
                            w_data_xfer ? r_word_cnt + 32'd1 : r_word_cnt;

    always_ff @(posedge BUS_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_word_cnt <= 32'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            r_word_cnt <= w_word_cnt_nxt;
            if (CLR_CNT) begin
                r_drop_cnt <= 16'd0;
            end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tjmono2_rx_stream_adapter.sv
// Scoreboard bench for tjmono2_rx_stream_adapter: modelled upstream FIFO, expected-word queue, negedge monitor.
module tb_tjmono2_rx_stream_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clr_cnt;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_read;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] word_cnt;
    logic [15:0] drop_cnt;
    logic        busy;

    logic [31:0] up_q[$];
    logic [31:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        last_pop;

    always #5 clk = ~clk;

    tjmono2_rx_stream_adapter #(.DATA_IDENTIFIER(4'h2)) dut (
        .BUS_CLK   (clk),
        .BUS_RST_N (rst_n),
        .ENABLE    (enable),
        .CLR_CNT   (clr_cnt),
        .FIFO_EMPTY(fifo_empty),
        .FIFO_DATA (fifo_data),
        .FIFO_READ (fifo_read),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .WORD_CNT  (word_cnt),
        .DROP_CNT  (drop_cnt),
        .BUSY      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic refresh();
        fifo_empty = (up_q.size() == 0);
        fifo_data  = (up_q.size() == 0) ? 32'h0 : up_q[0];
    endtask

    task automatic push_word(input logic [31:0] w, input bit expect_out);
        up_q.push_back(w);
        if (expect_out) exp_q.push_back(w);
        refresh();
    endtask

    // One clock: sample the pop request mid-cycle, apply it on the edge, redrive just after.
    task automatic step();
        @(negedge clk);
        last_pop = fifo_read;
        @(posedge clk);
        if (last_pop && up_q.size() != 0) void'(up_q.pop_front());
        #1;
        refresh();
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_empty(input int budget, input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            step();
            i++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares every transfer against the scoreboard and checks data hold under stall.
    initial begin
        logic        hold_v;
        logic [31:0] hold_d;
        hold_v = 1'b0;
        hold_d = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_valid", {31'b0, out_valid}, 32'd1);
                    check("hold_data", out_data, hold_d);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_out: got %h expected no word", out_data);
                    end else begin
                        check("out_data", out_data, exp_q.pop_front());
                    end
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  found;
        int  pops;

        rst_n     = 1'b1;
        enable    = 1'b0;
        clr_cnt   = 1'b0;
        out_ready = 1'b0;
        last_pop  = 1'b0;
        refresh();
        #2 rst_n = 1'b0;
        #3;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_read", {31'b0, fifo_read}, 32'd0);
        check("rst_word_cnt", word_cnt, 32'd0);
        check("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        steps(2);
        #1 rst_n = 1'b1;
        steps(4);
        enable = 1'b1;
        steps(2);
        check("run_busy", {31'b0, busy}, 32'd1);

        // Basic flow: one-cycle latency, one word per cycle.
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) push_word(32'h2000_0000 + 32'(i), 1'b1);
        steps(3);
        check("basic_cnt_mid", word_cnt, 32'd2);
        step();
        check("basic_cnt", word_cnt, 32'd3);
        wait_empty(10, "basic_drain");

        // Filtering.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        push_word(32'h3000_0005, 1'b0);
        push_word(32'h2000_0006, 1'b1);
        steps(5);
        check("filt_drop", {16'b0, drop_cnt}, 32'd1);
        check("filt_word", word_cnt, 32'd1);
        wait_empty(10, "filt_drain");

        // Backpressure.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(32'h2000_0010 + 32'(i), 1'b1);
        pops = 0;
        repeat (10) begin
            step();
            if (last_pop) pops++;
        end
        check("bp_pops", 32'(pops), 32'd2);
        check("bp_head", out_data, 32'h2000_0010);
        out_ready = 1'b1;
        wait_empty(30, "bp_drain");
        check("bp_word", word_cnt, 32'd6);

        // Counter edges.
        force dut.r_drop_cnt = 16'hFFFF;
        #1 release dut.r_drop_cnt;
        push_word(32'h3000_000F, 1'b0);
        steps(3);
        check("drop_sat", {16'b0, drop_cnt}, 32'h0000_FFFF);

        push_word(32'h2000_0020, 1'b1);
        step();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("clr_wins_word", word_cnt, 32'd0);
        check("clr_drop", {16'b0, drop_cnt}, 32'd0);

        force dut.r_word_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_word_cnt;
        push_word(32'h2000_0021, 1'b1);
        steps(3);
        check("word_wrap", word_cnt, 32'd0);
        wait_empty(10, "edge_drain");

        // Drain with two words buffered and WORD_CNT=7.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        for (int i = 1; i <= 7; i++) push_word(32'h2000_0030 + 32'(i), 1'b1);
        wait_empty(30, "pre_drain");
        check("pre_drain_word", word_cnt, 32'd7);
        out_ready = 1'b0;
        push_word(32'h2000_0038, 1'b1);
        push_word(32'h2000_0039, 1'b1);
        steps(4);
        enable = 1'b0;
        steps(2);
        check("drain_busy", {31'b0, busy}, 32'd1);
        out_ready = 1'b1;
`ifdef TJMONO2_STREAM_TRAILER_EN
        exp_q.push_back(32'h2E00_0009);
`endif
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check("drain_idle", {31'b0, busy}, 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_word", word_cnt, 32'd9);

        // Mid-operation reset with the buffer full.
        enable    = 1'b1;
        out_ready = 1'b0;
        steps(2);
        for (int i = 1; i <= 5; i++) push_word(32'h2000_0040 + 32'(i), 1'b1);
        steps(4);
        check("prerst_valid", {31'b0, out_valid}, 32'd1);
        check("prerst_data", out_data, 32'h2000_0041);
        out_ready = 1'b1;
        #1;
        check("prerst_read", {31'b0, fifo_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", {31'b0, out_valid}, 32'd0);
        check("mrst_data", out_data, 32'd0);
        check("mrst_read", {31'b0, fifo_read}, 32'd0);
        check("mrst_word_cnt", word_cnt, 32'd0);
        check("mrst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        steps(2);
        #1 rst_n = 1'b1;
        n = 0;
        found = 1'b0;
        while (!found && n < 8) begin
            @(negedge clk);
            if (fifo_read) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                n++;
            end
        end
        check("rel_edges", 32'(n), 32'd3);
        if (found) begin
            @(posedge clk);
            void'(up_q.pop_front());
            #1;
            refresh();
        end
        wait_empty(30, "mrst_drain");
        check("mrst_word", word_cnt, 32'd3);
        check("upstream_empty", 32'(up_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tjmono2_rx_stream_adapter.md
TJMONO2_RX_STREAM_ADAPTER -- requirements
Module: tjmono2_rx_stream_adapter

Interface
REQ-001 Parameter DATA_IDENTIFIER, default 4'h0, is the 4-bit tag that an accepted word carries in bits [31:28].
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 BUS_CLK  input  1  is the single clock; all logic is on its rising edge.
REQ-004 BUS_RST_N  input  1  is the asynchronous active-low reset.
REQ-005 ENABLE  input  1  is the run request; it is level-sensitive.
REQ-006 CLR_CNT  input  1  is a synchronous one-cycle pulse that clears WORD_CNT and DROP_CNT.
REQ-007 FIFO_EMPTY  input  1  is the upstream rx FIFO empty flag; the FIFO is first-word-fall-through.
REQ-008 FIFO_DATA  input  32  is the upstream head word; it is valid while FIFO_EMPTY=0.
REQ-009 FIFO_READ  output  1  pops the upstream head word in the same cycle.
REQ-010 OUT_DATA  output  32  is the downstream stream data.
REQ-011 OUT_VALID  output  1  is the downstream valid.
REQ-012 OUT_READY  input  1  is the downstream ready; a transfer occurs on a cycle where OUT_VALID=1 and OUT_READY=1.
REQ-013 WORD_CNT  output  32  counts transferred data words.
REQ-014 DROP_CNT  output  16  counts discarded words.
REQ-015 BUSY  output  1  is 1 whenever the state is not IDLE.

Function
REQ-016 The state machine SHALL have the states IDLE, RUN and DRAIN.
  - IDLE->RUN when ENABLE=1.
  - RUN->DRAIN when ENABLE=0.
  - DRAIN->IDLE when the buffer is empty and no trailer is pending.
  - DRAIN ignores ENABLE.
REQ-017 FIFO_READ SHALL be combinational and asserted only in RUN with FIFO_EMPTY=0, when either condition holds:
  - the head word will be discarded, or
  - the buffer occupancy is below 2, or an output transfer occurs this cycle.
REQ-018 A popped word with FIFO_DATA[31:28] not equal to DATA_IDENTIFIER SHALL be discarded and increment DROP_CNT; it is popped even when the buffer is full.
REQ-019 A popped matching word SHALL enter a 2-entry in-order buffer; OUT_VALID/OUT_DATA present the buffer head.
REQ-020 Latency SHALL be 1 cycle: a word popped on edge N drives OUT_VALID=1 after edge N.
REQ-021 With OUT_READY held at 1 and data available, throughput SHALL be one word per cycle with no bubbles.
REQ-022 Once OUT_VALID=1, OUT_DATA SHALL stay stable until the transfer completes.
REQ-023 No word SHALL be lost or duplicated under any OUT_READY pattern, including when a pop and a transfer happen on the same cycle with the buffer full.
REQ-024 WORD_CNT SHALL increment by 1 per data-word transfer, exclude trailer words, and wrap from FFFF_FFFF to 0.
REQ-025 DROP_CNT SHALL saturate at 16'hFFFF.
REQ-026 When CLR_CNT coincides with an increment, the counter SHALL read 0 after the edge (clear wins).
REQ-027 No pops SHALL occur in IDLE or DRAIN; words already in the buffer are still delivered in DRAIN.

Reset
REQ-028 Asserting BUS_RST_N=0 SHALL immediately force the following values, regardless of the current state, including mid-transfer:
  - state IDLE, buffer empty, trailer not pending;
  - OUT_VALID=0, OUT_DATA=0, FIFO_READ=0;
  - WORD_CNT=0, DROP_CNT=0, BUSY=0.
REQ-029 Reset SHALL discard buffered words without popping upstream.
REQ-030 Deassertion SHALL be synchronised internally to BUS_CLK (two-flop); the first pop can occur no earlier than the third edge after release.

Configuration
REQ-031 The macro TJMONO2_STREAM_TRAILER_EN SHALL control trailer emission.
REQ-032 With TJMONO2_STREAM_TRAILER_EN defined, DRAIN SHALL emit one trailer word after the buffer empties, then go to IDLE after the trailer transfers.
  - Trailer = {DATA_IDENTIFIER, 4'hE, WORD_CNT[23:0]}.
  - WORD_CNT is sampled at entry to DRAIN plus words transferred during DRAIN.
  - The trailer obeys the valid/ready rules.
REQ-033 Without TJMONO2_STREAM_TRAILER_EN, no trailer logic SHALL exist, and DRAIN->IDLE occurs on the cycle after the buffer becomes empty.

Verification
REQ-034 Basic flow: DATA_IDENTIFIER=2, ENABLE=1, OUT_READY=1, FIFO holds 20000001, 20000002, 20000003 -> these three words are output on consecutive cycles with 1-cycle latency, and WORD_CNT=3.
REQ-035 Filtering: FIFO holds 30000005, 20000006 -> 30000005 is popped and dropped, DROP_CNT=1, the only output word is 20000006, and WORD_CNT=1.
REQ-036 Backpressure: OUT_READY=0 for 10 cycles with 5 matching words queued -> FIFO_READ stops after 2 pops and OUT_DATA holds the first word; after release, all 5 are delivered in order with none lost.
REQ-037 Drain and trailer (macro on): ENABLE drops with 2 words buffered and WORD_CNT=7 -> 2 words are output, then trailer 2E000009, then BUSY=0; with the macro off, no trailer is output.
REQ-038 Counter edges:
  - DROP_CNT preloaded to FFFF plus a mismatching word -> DROP_CNT stays FFFF.
  - CLR_CNT on the same cycle as a transfer -> WORD_CNT=0.
  - WORD_CNT forced to FFFFFFFF plus one transfer -> WORD_CNT=0.
REQ-039 Mid-operation reset: BUS_RST_N pulsed low with the buffer full and OUT_VALID=1 -> all outputs read their reset values within the same cycle, and no FIFO_READ occurs until ENABLE is seen after synchronised release.
